// File: rtl/muldiv_issue_seq_if.sv
// Pipeline-side command/response channels of the mult/div issue sequencer.
// The master is the EX-stage decode; the slave is the sequencer.
interface muldiv_issue_seq_if;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_cmd;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_data;
    logic        rsp_err;

    modport master (
        output req_valid, req_cmd, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  req_valid, req_cmd, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/muldiv_issue_seq.sv
// Issues MULT/DIV to the ALU, waits out alu_stall (with timeout abort) and returns
// HI/LO over a valid/ready response; MFHI/MFLO read HI/LO without touching the ALU.
module muldiv_issue_seq #(
    parameter int unsigned TIMEOUT = 63,
    parameter logic [3:0]  OP_MULT = 4'hA,
    parameter logic [3:0]  OP_DIV  = 4'hB,
    parameter logic [3:0]  OP_IDLE = 4'hF
) (
    input  logic              clk,
    input  logic              rst_n,
    muldiv_issue_seq_if.slave io_bus,
    output logic [3:0]        o_alu_op,
    output logic [31:0]       o_alu_a,
    output logic [31:0]       o_alu_b,
    input  logic              i_alu_stall,
    input  logic [31:0]       i_alu_hi,
    input  logic [31:0]       i_alu_lo
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_CAPTURE,
        S_RESP
    } state_t;

    typedef enum logic [1:0] {
        CMD_MULT = 2'd0,
        CMD_DIV  = 2'd1,
        CMD_MFHI = 2'd2,
        CMD_MFLO = 2'd3
    } cmd_t;

    localparam logic [5:0] TIMEOUT_CNT = TIMEOUT[5:0];

    state_t      r_state;
    state_t      w_next_state;
    cmd_t        r_cmd;
    cmd_t        w_req_cmd;
    logic [3:0]  r_alu_op;
    logic [31:0] r_alu_a;
    logic [31:0] r_alu_b;
    logic [5:0]  r_cnt;
    logic [63:0] r_rsp_data;
    logic        r_rsp_err;
    logic        w_accept;
    logic        w_is_muldiv;
    logic        w_timeout;

    assign w_req_cmd   = cmd_t'(io_bus.req_cmd);
    assign w_accept    = io_bus.req_valid && (r_state == S_IDLE);
    assign w_is_muldiv = (w_req_cmd == CMD_MULT) || (w_req_cmd == CMD_DIV);
    assign w_timeout   = i_alu_stall && (r_cnt == TIMEOUT_CNT);

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values of its neighbours, independent of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: the default assignment up front keeps this block free of inferred latches.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next_state = w_is_muldiv ? S_ISSUE : S_CAPTURE;
                end
            end
            // A low stall here means the ALU recognised a repeat and HI/LO are current.
            S_ISSUE:   w_next_state = i_alu_stall ? S_WAIT : S_CAPTURE;
            S_WAIT: begin
                if (!i_alu_stall) begin
                    w_next_state = S_CAPTURE;
                end else if (w_timeout) begin
                    w_next_state = S_RESP;
                end
            end
            S_CAPTURE: w_next_state = S_RESP;
            S_RESP: begin
                if (io_bus.rsp_ready) begin
                    w_next_state = S_IDLE;
                end
            end
            default:   w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        io_bus.req_ready = (r_state == S_IDLE);
        io_bus.rsp_valid = (r_state == S_RESP);
        io_bus.rsp_data  = r_rsp_data;
        io_bus.rsp_err   = r_rsp_err;
        o_alu_op         = r_alu_op;
        o_alu_a          = r_alu_a;
        o_alu_b          = r_alu_b;
    end

    // Operands are only reloaded on accept so the ALU's duplicate-op compare stays stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cmd      <= CMD_MULT;
            r_alu_op   <= OP_IDLE;
            r_alu_a    <= '0;
            r_alu_b    <= '0;
            r_cnt      <= '0;
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_cmd <= w_req_cmd;
                        if (w_is_muldiv) begin
                            r_alu_a  <= io_bus.req_a;
                            r_alu_b  <= io_bus.req_b;
                            r_alu_op <= (w_req_cmd == CMD_MULT) ? OP_MULT : OP_DIV;
                        end
                    end
                end
                S_ISSUE: begin
                    r_alu_op <= OP_IDLE;
                    r_cnt    <= '0;
                end
                S_WAIT: begin
                    r_cnt <= r_cnt + 6'd1;
                    if (w_timeout) begin
                        r_rsp_err  <= 1'b1;
                        r_rsp_data <= '0;
                    end
                end
                S_CAPTURE: begin
                    r_rsp_err <= 1'b0;
                    case (r_cmd)
                        CMD_MFHI: r_rsp_data <= {32'b0, i_alu_hi};
                        CMD_MFLO: r_rsp_data <= {32'b0, i_alu_lo};
                        default:  r_rsp_data <= {i_alu_hi, i_alu_lo};
                    endcase
                end
                default: ;
            endcase
        end
    end

endmodule
